// File: rtl/rs232_pkg.sv
// rs232_pkg
//   Definitions shared by the RS-232 transmitter and the future receiver:
//   the frame state encoding and the bit-period computation.
//   No ports.
package rs232_pkg;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_START  = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
   localparam logic [2:0] S_PARITY = 3'd4;
   localparam logic [2:0] S_STOP   = 3'd5;

   typedef enum logic [2:0] {
      IDLE   = S_IDLE,
      FETCH  = S_FETCH,
      START  = S_START,
      DATA   = S_DATA,
      PARITY = S_PARITY,
      STOP   = S_STOP
   } rs232_state_e;

   // Clocks per line bit, integer-truncated. Callers need a result >= 4.
   function automatic int bit_ticks(input int clk_freq_hz, input int baud_rate);
      return clk_freq_hz / baud_rate;
   endfunction

endpackage

// File: rtl/rs232_transmitter_baud_tick_generator.sv
// baud_tick_generator
//   Down-counter producing a one-clock tick every TICKS clocks. While
//   restart is high the counter is held at its reload value, so the first
//   tick after restart drops arrives exactly TICKS clocks later.
// Ports
//   clk       in   system clock, rising edge
//   clear     in   asynchronous active-high reset
//   restart   in   synchronous reload / hold
//   tick      out  high on the last clock of each period
//   pre_tick  out  high on the clock before tick
module baud_tick_generator #(
   parameter int TICKS = 10
) (
   input  logic clk,
   input  logic clear,
   input  logic restart,
   output logic tick,
   output logic pre_tick
);

   localparam int CW = (TICKS < 2) ? 1 : $clog2(TICKS);
   localparam logic [CW-1:0] RELOAD = CW'(TICKS - 1);
   localparam logic [CW-1:0] ONE    = CW'(1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         cnt <= '0;
      end else if (restart || cnt == '0) begin
         cnt <= RELOAD;
      end else begin
         cnt <= cnt - ONE;
      end
   end

   assign tick     = (cnt == '0) && !restart;
   assign pre_tick = (cnt == ONE) && !restart;

endmodule

// File: rtl/rs232_transmitter.sv
// rs232_transmitter
//   UART serializer fed by a byte FIFO. Pops one word when enabled and data
//   is available, waits POP_LATENCY clocks for it, then sends start bit,
//   DATA_WIDTH data bits LSB first, optional even parity, and STOP_BITS stop
//   bits. All outputs are registered.
//   Macro QUICK_RS232_PARITY_EN adds the even-parity bit after the data bits.
// Ports
//   clk             in   system clock, rising edge
//   clear           in   asynchronous active-high reset
//   enable          in   allows new frames to start
//   data_available  in   upstream FIFO not empty
//   pop             out  one-clock pop request
//   in_data         in   popped word, valid POP_LATENCY clocks after pop
//   tx              out  serial line, idle high
//   busy            out  high from pop until the last stop bit ends
//   byte_sent       out  one-clock pulse on the last stop-bit clock
//
// state  | meaning
// IDLE   | line high, waiting for enable && data_available
// FETCH  | pop issued, waiting for the word to arrive
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | even parity bit (parity build only)
// STOP   | stop bit(s), byte_sent on the final clock
module rs232_transmitter
   import rs232_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int BAUD_RATE   = 115200,
   parameter int DATA_WIDTH  = 8,
   parameter int STOP_BITS   = 1,
   parameter int POP_LATENCY = 3
) (
   input  logic                  clk,
   input  logic                  clear,
   input  logic                  enable,
   input  logic                  data_available,
   output logic                  pop,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  tx,
   output logic                  busy,
   output logic                  byte_sent
);

   localparam int BIT_TICKS = bit_ticks(CLK_FREQ_HZ, BAUD_RATE);
   localparam int BW = $clog2(DATA_WIDTH);
   localparam int FW = (POP_LATENCY < 1) ? 1 : $clog2(POP_LATENCY + 1);

   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
   localparam logic [BW-1:0] BIT_ONE   = BW'(1);
   localparam logic [FW-1:0] LAST_WAIT = FW'(POP_LATENCY);
   localparam logic [FW-1:0] WAIT_ONE  = FW'(1);

   rs232_state_e          state;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [BW-1:0]         bit_cnt;
   logic [FW-1:0]         fetch_cnt;
   logic                  restart;
   logic                  tick;
   logic                  pre_tick;
`ifdef QUICK_RS232_PARITY_EN
   logic                  parity_bit;
`endif

   // Holding the bit timer in reload outside the bit-timed states makes the
   // start bit begin a full period on the clock after the word is latched.
   // Between bit states the transition coincides with the reload, so every
   // state entry starts a fresh period.
   assign restart = (state == IDLE) || (state == FETCH);

   baud_tick_generator #(
      .TICKS (BIT_TICKS)
   ) u_baud (
      .clk      (clk),
      .clear    (clear),
      .restart  (restart),
      .tick     (tick),
      .pre_tick (pre_tick)
   );

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state     <= IDLE;
         tx        <= 1'b1;
         pop       <= 1'b0;
         busy      <= 1'b0;
         byte_sent <= 1'b0;
         shift_reg <= '0;
         bit_cnt   <= '0;
         fetch_cnt <= '0;
`ifdef QUICK_RS232_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         pop       <= 1'b0;
         byte_sent <= 1'b0;
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (enable && data_available) begin
                  pop       <= 1'b1;
                  busy      <= 1'b1;
                  fetch_cnt <= '0;
                  state     <= FETCH;
               end
            end
            FETCH: begin
               if (fetch_cnt == LAST_WAIT) begin
                  shift_reg <= in_data;
`ifdef QUICK_RS232_PARITY_EN
                  parity_bit <= ^in_data;
`endif
                  tx        <= 1'b0;
                  state     <= START;
               end else begin
                  fetch_cnt <= fetch_cnt + WAIT_ONE;
               end
            end
            START: begin
               if (tick) begin
                  tx      <= shift_reg[0];
                  bit_cnt <= '0;
                  state   <= DATA;
               end
            end
            DATA: begin
               if (tick) begin
                  if (bit_cnt == LAST_DATA) begin
                     bit_cnt <= '0;
`ifdef QUICK_RS232_PARITY_EN
                     tx    <= parity_bit;
                     state <= PARITY;
`else
                     tx    <= 1'b1;
                     state <= STOP;
`endif
                  end else begin
                     shift_reg <= shift_reg >> 1;
                     tx        <= shift_reg[1];
                     bit_cnt   <= bit_cnt + BIT_ONE;
                  end
               end
            end
`ifdef QUICK_RS232_PARITY_EN
            PARITY: begin
               if (tick) begin
                  tx      <= 1'b1;
                  bit_cnt <= '0;
                  state   <= STOP;
               end
            end
`endif
            STOP: begin
               // byte_sent is registered, so it is raised one clock early
               // to land on the final stop-bit clock.
               if (pre_tick && bit_cnt == LAST_STOP) begin
                  byte_sent <= 1'b1;
               end
               if (tick) begin
                  if (bit_cnt == LAST_STOP) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + BIT_ONE;
                  end
               end
            end
            default: begin
               tx    <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rs232_transmitter.sv
module tb_rs232_transmitter;

   localparam int BT = 10;
`ifdef QUICK_RS232_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME_CLKS = NBITS * BT;
   localparam logic [7:0] POISON = 8'hC3;

   logic       clk = 1'b0;
   logic       clear;
   logic       enable;
   logic       data_available;
   logic       pop;
   logic [7:0] in_data;
   logic       tx;
   logic       busy;
   logic       byte_sent;

   logic       avail_gate;
   logic [7:0] words [16];
   int         n_push = 0;
   int         n_pop = 0;
   logic [7:0] d1 = POISON;
   logic [7:0] d2 = POISON;
   logic [7:0] d3 = POISON;
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   rs232_transmitter #(
      .CLK_FREQ_HZ (1_000_000),
      .BAUD_RATE   (100_000),
      .DATA_WIDTH  (8),
      .STOP_BITS   (1),
      .POP_LATENCY (3)
   ) dut (
      .clk            (clk),
      .clear          (clear),
      .enable         (enable),
      .data_available (data_available),
      .pop            (pop),
      .in_data        (in_data),
      .tx             (tx),
      .busy           (busy),
      .byte_sent      (byte_sent)
   );

   // Upstream FIFO model: word valid exactly 3 clocks after pop, poison otherwise.
   assign data_available = avail_gate && (n_push > n_pop);
   assign in_data = d3;

   always @(posedge clk) begin
      if (pop === 1'b1) begin
         d1    <= words[n_pop[3:0]];
         n_pop <= n_pop + 1;
      end else begin
         d1 <= POISON;
      end
      d2 <= d1;
      d3 <= d2;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] w);
      words[n_push[3:0]] = w;
      n_push++;
   endtask

   task automatic wait_pop(input string tag);
      int seen;
      seen = 0;
      for (int i = 0; i < 60; i++) begin
         if (pop === 1'b1) begin
            seen = 1;
            break;
         end
         tick();
      end
      check({tag, "_pop_seen"}, seen, 1);
   endtask

   // Counts idle-high clocks (and busy-low clocks among them) until the start bit.
   task automatic wait_start(input string tag, input int exp_gap, input int exp_busy_low);
      int gap;
      int bl;
      int found;
      gap = 0;
      bl = 0;
      found = 0;
      for (int i = 0; i < 200; i++) begin
         if (tx === 1'b0) begin
            found = 1;
            break;
         end
         gap++;
         if (busy === 1'b0) bl++;
         tick();
      end
      check({tag, "_start_seen"}, found, 1);
      check({tag, "_gap"}, gap, exp_gap);
      check({tag, "_busy_low_in_gap"}, bl, exp_busy_low);
   endtask

   // Called on the first start-bit clock; returns on the clock after the frame.
   task automatic expect_frame(input string tag, input logic [7:0] d, input int drop_at);
      logic [NBITS-1:0] fb;
      int bad;
      int bs_n;
      int bs_at;
      int bb;
      fb = '1;
      fb[0] = 1'b0;
      fb[8:1] = d;
`ifdef QUICK_RS232_PARITY_EN
      fb[9] = ^d;
`endif
      bad = 0;
      bs_n = 0;
      bs_at = -1;
      bb = 0;
      for (int i = 0; i < FRAME_CLKS; i++) begin
         if (i == drop_at) enable = 1'b0;
         if (tx !== fb[i / BT]) bad++;
         if (byte_sent === 1'b1) begin
            bs_n++;
            bs_at = i;
         end
         if (busy !== 1'b1) bb++;
         tick();
      end
      check({tag, "_tx_bit_errors"}, bad, 0);
      check({tag, "_byte_sent_count"}, bs_n, 1);
      check({tag, "_byte_sent_clk"}, bs_at, FRAME_CLKS - 1);
      check({tag, "_busy_drop_in_frame"}, bb, 0);
   endtask

   // Watches the line for n clocks; reports pops, low-line clocks, busy clocks.
   task automatic watch_idle(input string tag, input int n);
      int p0;
      int lo;
      int bh;
      p0 = n_pop;
      lo = 0;
      bh = 0;
      for (int i = 0; i < n; i++) begin
         if (tx !== 1'b1) lo++;
         if (busy !== 1'b0) bh++;
         tick();
      end
      check({tag, "_pops"}, n_pop - p0, 0);
      check({tag, "_tx_low"}, lo, 0);
      check({tag, "_busy_high"}, bh, 0);
   endtask

   initial begin
      clear = 1'b1;
      enable = 1'b0;
      avail_gate = 1'b0;
      tick();
      tick();
      tick();
      check("reset_tx", int'(tx), 1);
      check("reset_pop", int'(pop), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_byte_sent", int'(byte_sent), 0);
      clear = 1'b0;

      // data available but not enabled: nothing happens
      push(8'h55);
      avail_gate = 1'b1;
      watch_idle("disabled", 20);
      check("disabled_pop_total", n_pop, 0);

      // single frame 0x55
      enable = 1'b1;
      wait_pop("f55");
      wait_start("f55", 4, 0);
      expect_frame("f55", 8'h55, -1);
      check("f55_busy_after", int'(busy), 0);
      check("f55_pop_total", n_pop, 1);

      // back-to-back 0xA3 then 0x0F
      push(8'hA3);
      push(8'h0F);
      wait_pop("fA3");
      wait_start("fA3", 4, 0);
      expect_frame("fA3", 8'hA3, -1);
      check("fA3_single_pop", n_pop, 2);
      wait_start("f0F", 5, 1);
      expect_frame("f0F", 8'h0F, -1);
      watch_idle("after_pair", 30);
      check("pair_pop_total", n_pop, 3);

      // enable dropped mid-DATA with data still queued
      push(8'h33);
      push(8'h44);
      wait_pop("f33");
      wait_start("f33", 4, 0);
      expect_frame("f33", 8'h33, 35);
      watch_idle("en_dropped", 40);
      check("en_dropped_pop_total", n_pop, 4);
      check("en_dropped_avail", int'(data_available), 1);
      avail_gate = 1'b0;
      n_push = n_pop;

      // clear in the start bit: outputs return without a clock edge
      enable = 1'b1;
      push(8'h81);
      avail_gate = 1'b1;
      wait_pop("f81");
      wait_start("f81", 4, 0);
      #2;
      clear = 1'b1;
      #1;
      check("clr_start_tx", int'(tx), 1);
      check("clr_start_pop", int'(pop), 0);
      check("clr_start_busy", int'(busy), 0);
      check("clr_start_byte_sent", int'(byte_sent), 0);
      tick();
      clear = 1'b0;
      watch_idle("after_clr_start", 20);

      // clear in DATA bit 3 of 0xFF; no restart without a new pop
      push(8'hFF);
      wait_pop("fFF");
      wait_start("fFF", 4, 0);
      for (int i = 0; i < 45; i++) tick();
      check("fFF_busy_mid", int'(busy), 1);
      #2;
      clear = 1'b1;
      #1;
      check("clr_data_tx", int'(tx), 1);
      check("clr_data_busy", int'(busy), 0);
      tick();
      clear = 1'b0;
      watch_idle("after_clr_data", 30);

      // 0x07: parity bit 1 when parity is built in
      push(8'h07);
      wait_pop("f07");
      wait_start("f07", 4, 0);
      expect_frame("f07", 8'h07, -1);
      check("f07_pop_total", n_pop, 7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
